// File: rtl/mult_pkg.sv
// Shared definitions for the round-robin multiplier arbiter: default sizes,
// tag-width helper and the side-band tag carried alongside the product.
package mult_pkg;

  localparam int DEFAULT_WIDTH   = 8;
  localparam int DEFAULT_LATENCY = 2;
  localparam int MAX_ID_W        = 4;  // enough for 16 requesters

  function automatic int tag_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  typedef struct packed {
    logic                valid;
    logic [MAX_ID_W-1:0] id;
  } mult_tag_t;

endpackage

// File: rtl/mult_pipe.sv
// Pipelined full-width unsigned multiplier with a tag that travels in lockstep.
// Operands register at stage 0; the product then moves through LATENCY-1 stages.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int LATENCY = DEFAULT_LATENCY
) (
  input  logic               clk,
  input  logic               reset,
  input  mult_tag_t          in_tag,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output mult_tag_t          out_tag,
  output logic [2*WIDTH-1:0] out_prod
);

  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  mult_tag_t          tag0_q;
  logic [2*WIDTH-1:0] prod_d;

  // NOTE: only the valid bits are reset; operand and product registers are
  // qualified by valid, so clearing them would just cost reset fan-out.
  always_ff @(posedge clk) begin
    a_q    <= in_a;
    b_q    <= in_b;
    tag0_q <= in_tag;
    if (reset) tag0_q.valid <= 1'b0;
  end

  assign prod_d = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

  generate
    if (LATENCY == 1) begin : g_direct
      assign out_tag  = tag0_q;
      assign out_prod = prod_d;
    end else begin : g_stages
      mult_tag_t          tag_q  [LATENCY-1];
      logic [2*WIDTH-1:0] prod_q [LATENCY-1];

      always_ff @(posedge clk) begin
        tag_q[0]  <= tag0_q;
        prod_q[0] <= prod_d;
        for (int k = 1; k < LATENCY - 1; k++) begin
          tag_q[k]  <= tag_q[k-1];
          prod_q[k] <= prod_q[k-1];
        end
        if (reset) begin
          for (int k = 0; k < LATENCY - 1; k++) tag_q[k].valid <= 1'b0;
        end
      end

      assign out_tag  = tag_q[LATENCY-2];
      assign out_prod = prod_q[LATENCY-2];
    end
  endgenerate

endmodule

// File: rtl/mult_rr_arbiter.sv
// Round-robin front end sharing one pipelined multiplier among NUM_REQ lanes;
// the result returns to its owner LATENCY cycles after acceptance.
module mult_rr_arbiter
  import mult_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int WIDTH   = DEFAULT_WIDTH,
  parameter  int LATENCY = DEFAULT_LATENCY,
  localparam int ID_W    = tag_width(NUM_REQ),
  localparam int CNT_W   = $clog2(LATENCY + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [2*WIDTH-1:0]       rsp_prod,
  output logic [CNT_W-1:0]         in_flight,
  output logic                     busy
);

  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               transfer;
  mult_tag_t          in_tag;
  mult_tag_t          out_tag;
  logic [2*WIDTH-1:0] out_prod;
  logic               out_valid;
  logic [ID_W-1:0]    out_id;
  logic [ID_W-1:0]    hold_id;
  logic [2*WIDTH-1:0] hold_prod;

  // NOTE: combinational logic uses blocking assignments and sets every output
  // to a default first, so the scan reads its own updates and no latch appears.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_any && req_valid[(int'(rr_ptr) + k) % NUM_REQ]) begin
        grant_any = 1'b1;
        grant_idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_any && !reset) req_ready[grant_idx] = 1'b1;
  end

  assign transfer = grant_any & ~reset;
  assign in_tag   = '{valid: transfer, id: MAX_ID_W'(grant_idx)};

  mult_pipe #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_pipe (
    .clk      (clk),
    .reset    (reset),
    .in_tag   (in_tag),
    .in_a     (req_a[int'(grant_idx)*WIDTH +: WIDTH]),
    .in_b     (req_b[int'(grant_idx)*WIDTH +: WIDTH]),
    .out_tag  (out_tag),
    .out_prod (out_prod)
  );

  // Results landing while reset is high belong to discarded requests.
  assign out_valid = out_tag.valid & ~reset;
  assign out_id    = ID_W'(out_tag.id);

  always_comb begin
    rsp_valid = '0;
    if (out_valid) rsp_valid[out_id] = 1'b1;
  end

  assign rsp_id   = out_valid ? out_id   : hold_id;
  assign rsp_prod = out_valid ? out_prod : hold_prod;
  assign busy     = (in_flight != '0);

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr    <= '0;
      in_flight <= '0;
      hold_id   <= '0;
      hold_prod <= '0;
    end else begin
      if (transfer) begin
        rr_ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
      end
      case ({transfer, out_tag.valid})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
      if (out_valid) begin
        hold_id   <= out_id;
        hold_prod <= out_prod;
      end
    end
  end

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Directed-vector and scoreboard bench for mult_rr_arbiter (4 lanes, 8-bit, latency 2).
module tb_mult_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 8;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_prod;
  logic [1:0]  in_flight;
  logic        busy;

  mult_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .in_flight (in_flight),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
  endtask

  // Reference model: two-deep response pipeline and round-robin pointer.
  logic        m_v   [2];
  logic [1:0]  m_id  [2];
  logic [15:0] m_prod[2];
  int          model_ptr = 0;
  logic [3:0]  seen_ready;

  function automatic logic [3:0] model_arb(input int ptr, input logic [3:0] v);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(ptr + k) % NUM_REQ]) return 4'b0001 << ((ptr + k) % NUM_REQ);
    end
    return 4'b0000;
  endfunction

  // One clock cycle: drive inputs, check at the falling edge, advance the model.
  task automatic step(input logic rst, input logic [3:0] v, input logic [31:0] a,
                      input logic [31:0] b, input logic [3:0] exp_rdy, input string name);
    logic [3:0]  exp_rv;
    int          gid;
    logic [7:0]  opa, opb;
    reset     = rst;
    req_valid = v;
    req_a     = a;
    req_b     = b;
    @(negedge clk);
    seen_ready = req_ready;
    check({name, " req_ready"}, {28'd0, req_ready}, {28'd0, exp_rdy});
    exp_rv = (!rst && m_v[1]) ? (4'b0001 << m_id[1]) : 4'b0000;
    check({name, " rsp_valid"}, {28'd0, rsp_valid}, {28'd0, exp_rv});
    if (exp_rv != 4'b0000) begin
      check({name, " rsp_id"},   {30'd0, rsp_id},   {30'd0, m_id[1]});
      check({name, " rsp_prod"}, {16'd0, rsp_prod}, {16'd0, m_prod[1]});
    end
    if (!rst) begin
      check({name, " in_flight"}, {30'd0, in_flight}, 32'(m_v[0]) + 32'(m_v[1]));
      check({name, " busy"}, {31'd0, busy}, {31'd0, (m_v[0] | m_v[1])});
    end
    gid = 0;
    for (int i = 0; i < NUM_REQ; i++) if (exp_rdy[i]) gid = i;
    opa = a[gid*8 +: 8];
    opb = b[gid*8 +: 8];
    m_v[1]    = m_v[0];
    m_id[1]   = m_id[0];
    m_prod[1] = m_prod[0];
    m_v[0]    = !rst && (exp_rdy != 4'b0000);
    m_id[0]   = 2'(gid);
    m_prod[0] = 16'(opa) * 16'(opb);
    if (rst) begin
      m_v[0]    = 1'b0;
      m_v[1]    = 1'b0;
      model_ptr = 0;
    end else if (exp_rdy != 4'b0000) begin
      model_ptr = (gid + 1) % NUM_REQ;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0]  v;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rdy;
    string       name;
  } vec_t;

  vec_t tbl[$];

  logic        pend [NUM_REQ];
  logic [7:0]  pa   [NUM_REQ];
  logic [7:0]  pb   [NUM_REQ];
  int          wait_cnt [NUM_REQ];

  initial begin
    m_v[0] = 1'b0;
    m_v[1] = 1'b0;
    m_id[0] = '0; m_id[1] = '0;
    m_prod[0] = '0; m_prod[1] = '0;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    @(posedge clk);
    #1;

    // Reset: ready stays low even with every lane requesting.
    step(1'b1, 4'hF, 32'h0403_0201, 32'hFFFF_FFFF, 4'h0, "reset0");
    step(1'b1, 4'hF, 32'h0403_0201, 32'hFFFF_FFFF, 4'h0, "reset1");
    check("reset rsp_valid", {28'd0, rsp_valid}, 32'd0);
    check("reset rsp_id",    {30'd0, rsp_id},    32'd0);
    check("reset rsp_prod",  {16'd0, rsp_prod},  32'd0);
    check("reset in_flight", {30'd0, in_flight}, 32'd0);
    check("reset busy",      {31'd0, busy},      32'd0);

    // Single request from lane 2: 13*11 = 143.
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "idle"});
    tbl.push_back('{4'b0100, 32'h000D_0000, 32'h000B_0000, 4'b0100, "single_req2"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "single_wait"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "single_rsp"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "single_done"});
    // Max operands (255*255) and a zero operand; pointer is 3 here.
    tbl.push_back('{4'b0010, 32'h0000_FF00, 32'h0000_FF00, 4'b0010, "max_ops"});
    tbl.push_back('{4'b0001, 32'h0000_0000, 32'h0000_00C8, 4'b0001, "zero_op"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "ops_rsp0"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "ops_rsp1"});
    // Wrap: lane 3 granted, then lanes 0 and 3 contend with pointer at 0.
    tbl.push_back('{4'b1000, 32'h0500_0000, 32'h0600_0000, 4'b1000, "wrap_g3"});
    tbl.push_back('{4'b1001, 32'h0500_0003, 32'h0600_0007, 4'b0001, "wrap_g0"});
    tbl.push_back('{4'b1000, 32'h0500_0000, 32'h0600_0000, 4'b1000, "wrap_g3b"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "wrap_rsp0"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "wrap_rsp1"});
    // Lone requester granted every cycle regardless of pointer.
    tbl.push_back('{4'b0100, 32'h0007_0000, 32'h0003_0000, 4'b0100, "lone0"});
    tbl.push_back('{4'b0100, 32'h0009_0000, 32'h0003_0000, 4'b0100, "lone1"});
    tbl.push_back('{4'b0100, 32'h000B_0000, 32'h0003_0000, 4'b0100, "lone2"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "lone_rsp0"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "lone_rsp1"});
    // All lanes valid: a=i+1, b=255; grants 3 (to reach ptr 0), then 0,1,2,3,0.
    tbl.push_back('{4'b1000, 32'h0403_0201, 32'hFFFF_FFFF, 4'b1000, "all_prime"});
    tbl.push_back('{4'b1111, 32'h0403_0201, 32'hFFFF_FFFF, 4'b0001, "all_g0"});
    tbl.push_back('{4'b1111, 32'h0403_0201, 32'hFFFF_FFFF, 4'b0010, "all_g1"});
    tbl.push_back('{4'b1111, 32'h0403_0201, 32'hFFFF_FFFF, 4'b0100, "all_g2"});
    tbl.push_back('{4'b1111, 32'h0403_0201, 32'hFFFF_FFFF, 4'b1000, "all_g3"});
    tbl.push_back('{4'b1111, 32'h0403_0201, 32'hFFFF_FFFF, 4'b0001, "all_g0b"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "all_rsp0"});
    tbl.push_back('{4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "all_rsp1"});

    foreach (tbl[i]) step(1'b0, tbl[i].v, tbl[i].a, tbl[i].b, tbl[i].rdy, tbl[i].name);

    // Reset mid-operation: two accepted, reset before either result escapes.
    step(1'b0, 4'b0011, 32'h0000_0302, 32'h0000_0504, 4'b0010, "mid_g1");
    step(1'b0, 4'b0001, 32'h0000_0302, 32'h0000_0504, 4'b0001, "mid_g0");
    step(1'b1, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "mid_reset");
    step(1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "post_reset0");
    step(1'b0, 4'b1111, 32'h0403_0201, 32'h0202_0202, 4'b0001, "post_reset_g0");
    step(1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "post_reset1");
    step(1'b0, 4'b0000, 32'h0000_0000, 32'h0000_0000, 4'b0000, "post_reset2");

    // Random traffic against the model; lanes hold operands until accepted.
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0;
      pa[i] = '0;
      pb[i] = '0;
      wait_cnt[i] = 0;
    end
    for (int c = 0; c < 3000; c++) begin
      logic [3:0]  v;
      logic [31:0] a, b;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pa[i]   = 8'($urandom_range(0, 255));
          pb[i]   = 8'($urandom_range(0, 255));
        end
        v[i]        = pend[i];
        a[i*8 +: 8] = pend[i] ? pa[i] : 8'd0;
        b[i*8 +: 8] = pend[i] ? pb[i] : 8'd0;
      end
      step(1'b0, v, a, b, model_arb(model_ptr, v), "rand");
      for (int i = 0; i < NUM_REQ; i++) begin
        if (pend[i]) begin
          if (seen_ready[i]) begin
            check("rand fair_wait", 32'(wait_cnt[i] < NUM_REQ), 32'd1);
            pend[i]     = 1'b0;
            wait_cnt[i] = 0;
          end else begin
            wait_cnt[i]++;
            if (wait_cnt[i] >= NUM_REQ) begin
              check("rand starvation", 32'(wait_cnt[i]), 32'(NUM_REQ - 1));
              wait_cnt[i] = 0;
            end
          end
        end
      end
    end
    step(1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, "drain0");
    step(1'b0, 4'b0000, 32'h0, 32'h0, 4'b0000, "drain1");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
